// File: rtl/fifo_burst_reader_if.sv
// Read-side bundle: fall-through FIFO pop port plus the framed valid/ready output stream.
// Latency: none, wires only.
// Backpressure: m_ready from the consumer; fifo_rempty from the FIFO.
interface fifo_burst_reader_if #(
  parameter int DWIDTH = 8
);
  logic              fifo_r_en;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              fifo_rempty;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;

  // Reader side: pops the FIFO and drives the stream.
  modport master (
    output fifo_r_en,
    input  fifo_rdata,
    input  fifo_rempty,
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  // Environment side: FIFO read port and stream consumer.
  modport slave (
    input  fifo_r_en,
    output fifo_rdata,
    output fifo_rempty,
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pops a fall-through FIFO into a 2-entry buffer and emits BURST_LEN-word bursts with m_last framing.
// Latency: first beat valid 1 cycle after the first fifo_r_en; 1 word/cycle sustained.
// Backpressure: m_ready only gates the buffer drain; pops stop at cnt=2, never from m_ready directly.
// Optional FIFO_BURST_READER_PAD_EN: pads a starved burst with PAD_VALUE after TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int                DWIDTH    = 8,
  parameter int                BURST_LEN = 4,
  parameter int                TIMEOUT   = 16,
  parameter logic [DWIDTH-1:0] PAD_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  fifo_burst_reader_if.master bus,
  output logic               burst_done,
  output logic               pad_active
);
  localparam int            PW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW-1:0] LAST_BEAT = PW'(BURST_LEN - 1);

  if (BURST_LEN < 2) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT must be at least 1");
  end

  // Buffer: entry 0 is the head presented on the stream, entry 1 holds the next word.
  logic [1:0]        cnt;
  logic [DWIDTH-1:0] dat0, dat1;
  logic              last0, last1;
  logic [PW-1:0]     pull_cnt;

  logic              pull;
  logic              pad_load;
  logic              load;
  logic              load_last;
  logic [DWIDTH-1:0] load_dat;
  logic              xfer;
  logic              not_pad;

`ifdef FIFO_BURST_READER_PAD_EN
  localparam int            IW       = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

  state_t        state;
  logic [IW-1:0] idle_cnt;

  assign not_pad    = (state != PAD);
  assign pad_load   = (state == PAD) && (cnt != 2'd2);
  assign pad_active = (state == PAD);
`else
  // Without padding the burst is open exactly when pull_cnt != 0, so no separate state is kept.
  assign not_pad    = 1'b1;
  assign pad_load   = 1'b0;
  assign pad_active = 1'b0;
`endif

  // rst_n is in the pop term so the strobe drops the moment reset asserts, not at the next edge.
  assign pull      = rst_n & enable & ~bus.fifo_rempty & (cnt != 2'd2) & not_pad;
  assign load      = pull | pad_load;
  assign load_last = (pull_cnt == LAST_BEAT);
  assign load_dat  = pad_load ? PAD_VALUE : bus.fifo_rdata;
  assign xfer      = (cnt != 2'd0) & bus.m_ready;

  assign bus.fifo_r_en = pull;
  assign bus.m_valid   = (cnt != 2'd0);
  assign bus.m_data    = dat0;
  assign bus.m_last    = last0;

  // Buffer occupancy and ordering: load into the first free slot, shift on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      dat0  <= '0;
      dat1  <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else begin
      case (cnt)
        2'd0: begin
          if (load) begin
            dat0  <= load_dat;
            last0 <= load_last;
            cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (load && xfer) begin
            dat0  <= load_dat;
            last0 <= load_last;
          end else if (xfer) begin
            cnt <= 2'd0;
          end else if (load) begin
            dat1  <= load_dat;
            last1 <= load_last;
            cnt   <= 2'd2;
          end
        end
        default: begin
          if (xfer) begin
            dat0  <= dat1;
            last0 <= last1;
            cnt   <= 2'd1;
          end
        end
      endcase
    end
  end

  // Framing counter: advances per load so m_last is fixed when a word enters the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pull_cnt <= '0;
    end else if (load) begin
      pull_cnt <= load_last ? '0 : pull_cnt + PW'(1);
    end
  end

  // One-cycle pulse after the final beat of a burst is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_done <= 1'b0;
    end else begin
      burst_done <= xfer & last0;
    end
  end

`ifdef FIFO_BURST_READER_PAD_EN
  // Burst FSM with starvation timer; only a starved, enabled open burst escalates to padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (load && !load_last) state <= STREAM;
        end
        STREAM: begin
          if (load) begin
            idle_cnt <= '0;
            if (load_last) state <= IDLE;
          end else if (!enable) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_MAX) begin
            idle_cnt <= '0;
            state    <= PAD;
          end else if (bus.fifo_rempty) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        PAD: begin
          idle_cnt <= '0;
          if (pad_load && load_last) state <= IDLE;
        end
        default: begin
          idle_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end
`endif

endmodule
